// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= BCD_DIGIT_W'(5)) ? digit_i + BCD_DIGIT_W'(3) : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with valid/ready
// handshakes, optional two's-complement input and sticky overflow flag.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BIN_W-1:0]              bin_in,
  input  logic                          signed_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          neg_out,
  output logic                          ovf_out,
  output logic                          busy
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   mag_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               neg_q;
  logic               ovf_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BIN_W-1:0]   mag_in;
  logic               neg_in;
  logic               accept;
  logic               last_shift;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit_i(bcd_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .digit_o(bcd_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // The most negative input negates to itself, which as an unsigned
  // magnitude is exactly 2^(BIN_W-1).
  assign neg_in     = signed_in & bin_in[BIN_W-1];
  assign mag_in     = neg_in ? (~bin_in + BIN_W'(1)) : bin_in;
  assign accept     = in_valid & in_ready;
  assign last_shift = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)   state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q <= '0;
      bcd_q <= '0;
      neg_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      mag_q <= mag_in;
      bcd_q <= '0;
      neg_q <= neg_in;
      ovf_q <= 1'b0;
      cnt_q <= CNT_W'(BIN_W - 1);
    end else if (state_q == SHIFT) begin
      // Adjusted digits shift up one bit; the bit leaving the top digit is lost.
      {bcd_q, mag_q} <= {bcd_adj[BCD_W-2:0], mag_q, 1'b0};
      ovf_q          <= ovf_q | bcd_adj[BCD_W-1];
      if (!last_shift) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign bcd_out = bcd_q;
  assign neg_out = neg_q;
  assign ovf_out = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomised bench for bin2bcd_seq against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;

  // 16-bit, 5-digit instance
  logic        in_valid, in_ready, signed_in, out_valid, out_ready;
  logic [15:0] bin_in;
  logic [19:0] bcd_out;
  logic        neg_out, ovf_out, busy;

  // 16-bit, 4-digit instance (overflow behaviour)
  logic        in_valid4, in_ready4, signed_in4, out_valid4, out_ready4;
  logic [15:0] bin_in4;
  logic [15:0] bcd_out4;
  logic        neg_out4, ovf_out4, busy4;

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .bin_in(bin_in), .signed_in(signed_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .bcd_out(bcd_out), .neg_out(neg_out), .ovf_out(ovf_out), .busy(busy)
  );

  bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .bin_in(bin_in4), .signed_in(signed_in4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .bcd_out(bcd_out4), .neg_out(neg_out4), .ovf_out(ovf_out4), .busy(busy4)
  );

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: plain decimal arithmetic on the magnitude.
  function automatic void model(input logic [15:0] v, input logic s, input int digits,
                                output logic [39:0] bcd, output logic n, output logic o);
    longint m, lim;
    n = s && v[15];
    m = n ? (longint'(65536) - longint'(v)) : longint'(v);
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    o = (m >= lim);
    bcd = '0;
    for (int i = 0; i < digits; i++) begin
      bcd[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
  endfunction

  typedef struct {
    logic [39:0] bcd;
    logic        n;
    logic        o;
    int          acc;
  } exp_t;

  exp_t q[$];

  // Per-cycle compare of the 5-digit instance against the outstanding-request model.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      chk("rst_in_ready", 40'(in_ready), 40'd1);
      chk("rst_busy", 40'(busy), 40'd0);
      chk("rst_out_valid", 40'(out_valid), 40'd0);
      chk("rst_bcd", 40'(bcd_out), 40'd0);
      chk("rst_neg_ovf", 40'({neg_out, ovf_out}), 40'd0);
    end else begin
      logic exp_ov;
      exp_t e;
      exp_ov = (q.size() > 0) && (cyc >= q[0].acc + 16);
      chk("in_ready", 40'(in_ready), 40'(q.size() == 0));
      chk("busy", 40'(busy), 40'(q.size() != 0));
      chk("out_valid", 40'(out_valid), 40'(exp_ov));
      if (exp_ov && out_valid) begin
        chk("bcd_out", 40'(bcd_out), q[0].bcd);
        chk("neg_out", 40'(neg_out), 40'(q[0].n));
        chk("ovf_out", 40'(ovf_out), 40'(q[0].o));
      end
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        model(bin_in, signed_in, 5, e.bcd, e.n, e.o);
        e.acc = cyc + 1;
        q.push_back(e);
      end
    end
  end

  // Called just after a rising edge; returns the result seen while out_valid was high.
  task automatic run(input logic [15:0] v, input logic s, input int hold,
                     output logic [19:0] bcd, output logic n, output logic o);
    int t;
    t = 0;
    while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
    in_valid = 1'b1; bin_in = v; signed_in = s;
    @(posedge clk); #1;
    t = 0;
    while (!out_valid && t < 100) begin
      in_valid = 1'($urandom); bin_in = 16'($urandom); signed_in = 1'($urandom);
      @(posedge clk); #1; t++;
    end
    chk("out_valid_seen", 40'(out_valid), 40'd1);
    repeat (hold) begin
      in_valid = 1'($urandom); bin_in = 16'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    bcd = bcd_out; n = neg_out; o = ovf_out;
    $display("conv %h signed=%0d -> bcd %h neg %0d ovf %0d (hold %0d)", v, s, bcd, n, o, hold);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_take", 40'(in_ready), 40'd1);
  endtask

  task automatic run4(input logic [15:0] v, input logic s,
                      output logic [15:0] bcd, output logic n, output logic o);
    int t;
    in_valid4 = 1'b1; bin_in4 = v; signed_in4 = s;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    t = 0;
    while (!out_valid4 && t < 100) begin @(posedge clk); #1; t++; end
    chk("out_valid4_seen", 40'(out_valid4), 40'd1);
    bcd = bcd_out4; n = neg_out4; o = ovf_out4;
    $display("conv4 %h signed=%0d -> bcd %h neg %0d ovf %0d", v, s, bcd, n, o);
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] b;
    logic [15:0] b4;
    logic        n, o;
    logic [39:0] eb;
    logic        en, eo;
    logic [15:0] v;
    logic        s;

    in_valid = 0; bin_in = '0; signed_in = 0; out_ready = 0;
    in_valid4 = 0; bin_in4 = '0; signed_in4 = 0; out_ready4 = 0;

    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Hand-computed expectations
    run(16'hFFFF, 1'b0, 0, b, n, o);
    chk("u65535_bcd", 40'(b), 40'h65535);
    chk("u65535_flags", 40'({n, o}), 40'd0);
    run(16'hFFFF, 1'b1, 1, b, n, o);
    chk("sm1_bcd", 40'(b), 40'h00001);
    chk("sm1_neg", 40'(n), 40'd1);
    run(16'h8000, 1'b1, 2, b, n, o);
    chk("smin_bcd", 40'(b), 40'h32768);
    chk("smin_neg", 40'(n), 40'd1);
    run(16'h0000, 1'b1, 0, b, n, o);
    chk("s0_bcd", 40'(b), 40'h00000);
    chk("s0_neg", 40'(n), 40'd0);

    // Consumer stalls in DONE with in_valid noise
    run(16'd31337, 1'b0, 10, b, n, o);
    chk("stall_bcd", 40'(b), 40'h31337);

    for (int i = 0; i < 30; i++) begin
      v = 16'($urandom); s = 1'($urandom);
      run(v, s, int'($urandom_range(0, 3)), b, n, o);
      model(v, s, 5, eb, en, eo);
      chk("rand_bcd", 40'(b), eb);
      chk("rand_flags", 40'({n, o}), 40'({en, eo}));
    end

    // Asynchronous reset in the middle of a conversion
    in_valid = 1'b1; bin_in = 16'd1234; signed_in = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 40'(out_valid), 40'd0);
    chk("async_busy", 40'(busy), 40'd0);
    chk("async_bcd", 40'(bcd_out), 40'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    run(16'd4096, 1'b0, 0, b, n, o);
    chk("post_rst_bcd", 40'(b), 40'h04096);

    // Four-digit instance: overflow then clean conversion
    run4(16'd12345, 1'b0, b4, n, o);
    chk("d4_12345_bcd", 40'(b4), 40'h2345);
    chk("d4_12345_ovf", 40'(o), 40'd1);
    run4(16'd9999, 1'b0, b4, n, o);
    chk("d4_9999_bcd", 40'(b4), 40'h9999);
    chk("d4_9999_ovf", 40'(o), 40'd0);
    for (int i = 0; i < 10; i++) begin
      v = 16'($urandom); s = 1'($urandom);
      run4(v, s, b4, n, o);
      model(v, s, 4, eb, en, eo);
      chk("d4_rand_bcd", 40'(b4), eb);
      chk("d4_rand_flags", 40'({n, o}), 40'({en, eo}));
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter BIN_W, default 16: binary input width, legal range 4..32.
REQ-002 SHALL have parameter DIGITS, default 5: number of BCD output digits, legal range 1..10.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: the request carries a conversion operand.
REQ-006 SHALL have port in_ready, output, 1: block accepts a request.
REQ-007 SHALL have port bin_in, input, BIN_W: operand to convert.
REQ-008 SHALL have port signed_in, input, 1: 1 = treat bin_in as two's complement.
REQ-009 SHALL have port out_valid, output, 1: result is held on the outputs.
REQ-010 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-011 SHALL have port bcd_out, output, 4*DIGITS: packed digits; digit 0 (ones) is in bits [3:0].
REQ-012 SHALL have port neg_out, output, 1: result is negative.
REQ-013 SHALL have port ovf_out, output, 1: magnitude exceeded DIGITS digits.
REQ-014 SHALL have port busy, output, 1: state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-016 SHALL assert in_ready only in IDLE; a request is accepted on the edge where in_valid and in_ready are both high.
REQ-017 On accept, SHALL latch the magnitude, clear the BCD register and the ovf flag, load the bit counter with BIN_W-1, and enter SHIFT.
REQ-018 Magnitude: SHALL be bin_in if signed_in=0 or the MSB is 0; otherwise SHALL be the BIN_W-bit two's-complement negation (-2^(BIN_W-1) yields 2^(BIN_W-1)).
REQ-019 neg_out SHALL equal signed_in AND bin_in MSB, latched at accept; zero is never negative.
REQ-020 Each SHIFT cycle, SHALL first add 3 to every digit that is >= 5, then shift {bcd, magnitude} left by 1, taking the magnitude MSB into digit 0 bit 0.
REQ-021 SHALL set ovf sticky when the bit shifted out of the top digit's bit 3 is 1.
REQ-022 SHALL perform exactly BIN_W SHIFT cycles; after the shift with counter = 0, SHALL enter DONE.
REQ-023 SHALL assert out_valid exactly in DONE; accept edge N gives out_valid high after edge N+BIN_W.
REQ-024 In DONE, bcd_out, neg_out and ovf_out SHALL stay stable until out_ready is high at a rising edge; the FSM then returns to IDLE.
REQ-025 SHALL NOT accept a new request in the DONE cycle; throughput is one conversion per BIN_W+2 cycles minimum.
REQ-026 On overflow, bcd_out SHALL hold the low DIGITS digits of the true value.
REQ-027 in_valid and bin_in SHALL be ignored outside IDLE.

Reset
REQ-028 When rst_n is low, SHALL immediately set state to IDLE and bcd_out, neg_out, ovf_out, out_valid, busy and the counter to 0, and in_ready to 1, regardless of any in-flight conversion.
REQ-029 After rst_n deasserts, the first rising edge SHALL already be able to accept a request.

Structure
REQ-030 Package bcd_pkg SHALL hold the FSM state typedef and the constant BCD_DIGIT_W = 4.
REQ-031 SHALL instantiate DIGITS copies of combinational sub-module bcd_digit_adj (4-bit in, +3 if >= 5, 4-bit out); everything else SHALL be in bin2bcd_seq.

Verification
REQ-032 BIN_W=16, DIGITS=5: unsigned 65535 accepted at edge 0 -> out_valid after edge 16, bcd_out 0x65535, neg 0, ovf 0.
REQ-033 BIN_W=16, DIGITS=4: 12345 -> bcd_out 0x2345, ovf 1; then 9999 -> 0x9999, ovf 0 (ovf flag cleared).
REQ-034 Signed mode: 0xFFFF -> 0x00001 with neg 1; 0x8000 -> 0x32768 with neg 1; 0x0000 -> 0x00000 with neg 0.
REQ-035 out_ready held low 10 cycles in DONE -> outputs stable, in_ready 0, in_valid pulses ignored; then out_ready high -> in_ready 1 next cycle.
REQ-036 rst_n low in SHIFT cycle 7 -> out_valid 0 and busy 0 asynchronously; after release, convert 4096 -> 0x04096 with correct latency.
